dino_player: RTL and testbench

- Parametrised second-generation player controller for the dino runner game.
- Owns the player FSM: stop, run, jump, duck and die.
- Computes gravity-based vertical jump physics and sprite animation frame selection.
- Single clock domain; physics and animation advance on a one-cycle frame strobe `tick`. Outputs feed the sprite renderer and the collision unit.

---
 rtl/dino_pkg.sv | 27 ++
 rtl/dino_player_if.sv | 31 +++
 rtl/dino_anim_counter.sv | 68 ++++++
 rtl/dino_player.sv | 206 ++++++++++++++++++++
 tb/tb_dino_player.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dino_pkg.sv
// Shared definitions for the dino runner player block: state encoding,
// coordinate widths used by the renderer and collision unit, and a width helper.
package dino_pkg;

  // Player FSM state encoding (3-bit, legacy-compatible constants)
  typedef logic [2:0] dino_state_t;

  localparam dino_state_t ST_STOP = 3'd0;
  localparam dino_state_t ST_RUN  = 3'd1;
  localparam dino_state_t ST_JUMP = 3'd2;
  localparam dino_state_t ST_DUCK = 3'd3;
  localparam dino_state_t ST_DIE  = 3'd4;

  // Screen coordinate widths shared with the renderer and collision unit
  localparam int DINO_X_W = 10;
  localparam int DINO_Y_W = 9;

  // Counter width for n values, never below one bit
  function automatic int dino_frame_w(input int n);
    if (n > 1) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/dino_player_if.sv
// Player controller bundle: game controls in, sprite position/status out.
interface dino_player_if
  import dino_pkg::*;
#(
  parameter int X_W  = DINO_X_W,
  parameter int Y_W  = DINO_Y_W,
  parameter int AF_W = 1
);
  logic            tick;
  logic            start;
  logic            up;
  logic            down;
  logic            kill;
  logic [X_W-1:0]  x;
  logic [Y_W-1:0]  y;
  logic [2:0]      state;
  logic [AF_W-1:0] anim_frame;
  logic            airborne;
  logic            landed;
  logic            anim_wrap;   // one-clk pulse when the sprite frame advances

  modport master (
    output tick, start, up, down, kill,
    input  x, y, state, anim_frame, airborne, landed, anim_wrap
  );

  modport slave (
    input  tick, start, up, down, kill,
    output x, y, state, anim_frame, airborne, landed, anim_wrap
  );
endinterface

// File: rtl/dino_anim_counter.sv
// Sprite animation counter: a tick divider feeding a wrapping frame index.
// wrap_o pulses together with each frame advance.
module dino_anim_counter
  import dino_pkg::*;
#(
  parameter int ANIM_FRAMES = 2,
  parameter int ANIM_DIV    = 8,
  localparam int AF_W = dino_frame_w(ANIM_FRAMES),
  localparam int DW   = dino_frame_w(ANIM_DIV)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en_i,
  input  logic            clr_i,
  output logic [AF_W-1:0] frame_o,
  output logic            wrap_o
);

  localparam logic [DW-1:0]   DIV_LAST   = DW'(ANIM_DIV - 1);
  localparam logic [AF_W-1:0] FRAME_LAST = AF_W'(ANIM_FRAMES - 1);

  logic [DW-1:0]   div_q, div_d;
  logic [AF_W-1:0] frame_q, frame_d;
  logic            wrap_q, wrap_d;

  // Next divider/frame: clear wins, otherwise count enabled ticks
  always_comb begin
    div_d   = div_q;
    frame_d = frame_q;
    wrap_d  = 1'b0;
    if (clr_i) begin
      div_d   = '0;
      frame_d = '0;
    end else if (en_i) begin
      if (div_q == DIV_LAST) begin
        div_d  = '0;
        wrap_d = 1'b1;
        if (frame_q == FRAME_LAST) begin
          frame_d = '0;
        end else begin
          frame_d = frame_q + AF_W'(1);
        end
      end else begin
        div_d = div_q + DW'(1);
      end
    end else begin
      div_d   = div_q;
      frame_d = frame_q;
    end
  end

  // Counter registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q   <= '0;
      frame_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      div_q   <= div_d;
      frame_q <= frame_d;
      wrap_q  <= wrap_d;
    end
  end

  assign frame_o = frame_q;
  assign wrap_o  = wrap_q;

endmodule

// File: rtl/dino_player.sv
// Dino runner player controller: stop/run/jump/duck/die FSM, gravity jump
// physics and sprite animation. Physics/animation advance on the frame tick.
// Build option DINO_VAR_JUMP_EN: releasing up mid-rise cuts the jump short.
module dino_player
  import dino_pkg::*;
#(
  parameter int X_W         = DINO_X_W,
  parameter int Y_W         = DINO_Y_W,
  parameter int V_W         = 6,
  parameter int INIT_X      = 50,
  parameter int GROUND_Y    = 400,
  parameter int JUMP_V      = 12,
  parameter int GRAVITY     = 1,
  parameter int FASTFALL_G  = 3,
  parameter int ANIM_FRAMES = 2,
  parameter int ANIM_DIV    = 8
) (
  input  logic         clk,
  input  logic         rst,
  dino_player_if.slave bus
);

  localparam int AF_W = dino_frame_w(ANIM_FRAMES);
  localparam int PW   = Y_W + 2;   // signed position arithmetic
  localparam int GW   = V_W + 3;   // velocity update with room below the floor

  localparam logic signed [V_W-1:0] VY_JUMP  = V_W'(JUMP_V);
  localparam logic signed [V_W-1:0] VY_MIN   = {1'b1, {(V_W-1){1'b0}}};
  localparam logic signed [V_W-1:0] VY_ZERO  = '0;
  localparam logic signed [PW-1:0]  GROUND_S = PW'(GROUND_Y);
  localparam logic [Y_W-1:0]        GROUND_U = Y_W'(GROUND_Y);
  localparam logic signed [GW-1:0]  G_SLOW   = GW'(GRAVITY);
  localparam logic signed [GW-1:0]  G_FAST   = GW'(FASTFALL_G);
`ifdef DINO_VAR_JUMP_EN
  localparam logic signed [V_W-1:0] VY_HALF  = V_W'(JUMP_V / 2);
`endif

  dino_state_t            state_q, state_d;
  logic [Y_W-1:0]         y_q, y_d;
  logic signed [V_W-1:0]  vy_q, vy_d;
  logic                   landed_q, landed_d;
  logic                   airborne_q, airborne_d;

  logic                   up_only_s, down_only_s;
  logic signed [V_W-1:0]  vy_use_s, vy_next_s;
  logic signed [PW-1:0]   y_new_s;
  logic signed [GW-1:0]   vy_wide_s;
  logic [Y_W-1:0]         y_step_s;
  logic                   touchdown_s;
  logic                   anim_en_s, anim_clr_s, anim_wrap_s;
  logic [AF_W-1:0]        anim_frame_s;

  // Button decode: both pressed together means no input
  always_comb begin
    up_only_s   = bus.up & ~bus.down;
    down_only_s = bus.down & ~bus.up;
  end

  // One tick of jump physics: position step, gravity, floor clamp, touchdown
  always_comb begin
    vy_use_s = vy_q;
`ifdef DINO_VAR_JUMP_EN
    if (!bus.up && (vy_q > VY_HALF)) begin
      vy_use_s = VY_HALF;
    end else begin
      vy_use_s = vy_q;
    end
`endif
    y_new_s = signed'(PW'(y_q)) - PW'(vy_use_s);
    if (bus.down) begin
      vy_wide_s = GW'(vy_use_s) - G_FAST;
    end else begin
      vy_wide_s = GW'(vy_use_s) - G_SLOW;
    end
    if (vy_wide_s < GW'(VY_MIN)) begin
      vy_next_s = VY_MIN;
    end else begin
      vy_next_s = V_W'(vy_wide_s);
    end
    if (y_new_s[PW-1]) begin
      y_step_s = '0;
    end else begin
      y_step_s = y_new_s[Y_W-1:0];
    end
    touchdown_s = (vy_use_s <= VY_ZERO) && (y_new_s >= GROUND_S);
  end

  // Player FSM and physics next-state
  always_comb begin
    state_d  = state_q;
    y_d      = y_q;
    vy_d     = vy_q;
    landed_d = 1'b0;
    case (state_q)
      ST_STOP: begin
        if (bus.start) begin
          state_d = ST_RUN;
          y_d     = GROUND_U;
          vy_d    = VY_ZERO;
        end else begin
          state_d = ST_STOP;
        end
      end
      ST_RUN: begin
        if (bus.kill) begin
          state_d = ST_DIE;
        end else if (up_only_s) begin
          state_d = ST_JUMP;
          vy_d    = VY_JUMP;
        end else if (down_only_s) begin
          state_d = ST_DUCK;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DUCK: begin
        if (bus.kill) begin
          state_d = ST_DIE;
        end else if (up_only_s) begin
          state_d = ST_JUMP;
          vy_d    = VY_JUMP;
        end else if (!down_only_s) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_DUCK;
        end
      end
      ST_JUMP: begin
        if (bus.kill) begin
          state_d = ST_DIE;
        end else if (bus.tick) begin
          if (touchdown_s) begin
            y_d      = GROUND_U;
            vy_d     = VY_ZERO;
            landed_d = 1'b1;
            state_d  = down_only_s ? ST_DUCK : ST_RUN;
          end else begin
            y_d  = y_step_s;
            vy_d = vy_next_s;
          end
        end else begin
          state_d = ST_JUMP;
        end
      end
      ST_DIE: begin
        if (bus.start) begin
          state_d = ST_RUN;
          y_d     = GROUND_U;
          vy_d    = VY_ZERO;
        end else begin
          state_d = ST_DIE;
        end
      end
      default: begin
        state_d = ST_STOP;
        y_d     = GROUND_U;
        vy_d    = VY_ZERO;
      end
    endcase
    airborne_d = (state_d == ST_JUMP);
  end

  // Animation runs on ticks in RUN/DUCK; cleared in STOP and on restart
  always_comb begin
    anim_en_s  = bus.tick & ((state_q == ST_RUN) | (state_q == ST_DUCK));
    anim_clr_s = (state_q == ST_STOP) | ((state_q == ST_DIE) & bus.start);
  end

  // Player state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_STOP;
      y_q        <= GROUND_U;
      vy_q       <= VY_ZERO;
      landed_q   <= 1'b0;
      airborne_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      y_q        <= y_d;
      vy_q       <= vy_d;
      landed_q   <= landed_d;
      airborne_q <= airborne_d;
    end
  end

  dino_anim_counter #(
    .ANIM_FRAMES (ANIM_FRAMES),
    .ANIM_DIV    (ANIM_DIV)
  ) u_anim (
    .clk     (clk),
    .rst     (rst),
    .en_i    (anim_en_s),
    .clr_i   (anim_clr_s),
    .frame_o (anim_frame_s),
    .wrap_o  (anim_wrap_s)
  );

  assign bus.x          = X_W'(INIT_X);
  assign bus.y          = y_q;
  assign bus.state      = state_q;
  assign bus.anim_frame = anim_frame_s;
  assign bus.airborne   = airborne_q;
  assign bus.landed     = landed_q;
  assign bus.anim_wrap  = anim_wrap_s;

endmodule

// File: tb/tb_dino_player.sv
// Bench for dino_player: integer game model compared every cycle, plus
// hand-computed expectations along the directed game scenarios.
module tb_dino_player;

  localparam int S_STOP = 0, S_RUN = 1, S_JUMP = 2, S_DUCK = 3, S_DIE = 4;
  localparam int INIT_X = 50, GROUND_Y = 400, JUMP_V = 12;
  localparam int GRAVITY = 1, FASTFALL_G = 3, VY_FLOOR = -32;
  localparam int ANIM_FRAMES = 2, ANIM_DIV = 8;
`ifdef DINO_VAR_JUMP_EN
  localparam bit VAR_JUMP = 1'b1;
`else
  localparam bit VAR_JUMP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errs   = 0;
  bit   hu;

  dino_player_if bus ();

  dino_player dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- game model (plain integers) ----------------
  int m_state = S_STOP, m_y = GROUND_Y, m_vy = 0, m_cnt = 0;
  bit m_land = 1'b0, m_air = 1'b0, m_wrap = 1'b0;

  task automatic model_step();
    int  vy_use, ny, nvy;
    bit  upe, dne;
    m_land = 1'b0;
    m_wrap = 1'b0;
    if (rst) begin
      m_state = S_STOP; m_y = GROUND_Y; m_vy = 0; m_cnt = 0; m_air = 1'b0;
      return;
    end
    upe = bus.up && !bus.down;
    dne = bus.down && !bus.up;
    // m_cnt = ticks spent running since the last clear
    if (m_state == S_STOP || (m_state == S_DIE && bus.start)) m_cnt = 0;
    else if (bus.tick && (m_state == S_RUN || m_state == S_DUCK)) begin
      m_cnt++;
      m_wrap = (m_cnt % ANIM_DIV) == 0;
    end
    case (m_state)
      S_STOP: if (bus.start) m_state = S_RUN;
      S_RUN, S_DUCK: begin
        if (bus.kill) m_state = S_DIE;
        else if (upe) begin m_state = S_JUMP; m_vy = JUMP_V; end
        else if (dne) m_state = S_DUCK;
        else m_state = S_RUN;
      end
      S_JUMP: if (bus.kill) m_state = S_DIE;
        else if (bus.tick) begin
          vy_use = m_vy;
          if (VAR_JUMP && !bus.up && vy_use > JUMP_V / 2) vy_use = JUMP_V / 2;
          ny  = m_y - vy_use;
          nvy = vy_use - (bus.down ? FASTFALL_G : GRAVITY);
          if (nvy < VY_FLOOR) nvy = VY_FLOOR;
          if (vy_use <= 0 && ny >= GROUND_Y) begin
            m_y = GROUND_Y; m_vy = 0; m_land = 1'b1;
            m_state = dne ? S_DUCK : S_RUN;
          end else begin
            m_y = (ny < 0) ? 0 : ny;
            m_vy = nvy;
          end
        end
      S_DIE: if (bus.start) begin m_state = S_RUN; m_y = GROUND_Y; m_vy = 0; end
      default: m_state = S_STOP;
    endcase
    m_air = (m_state == S_JUMP);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Every-cycle comparison against the model, away from the clock edge
  initial begin
    forever begin
      @(negedge clk);
      chk("state", bus.state, m_state);
      chk("x", bus.x, INIT_X);
      chk("y", bus.y, m_y);
      chk("anim_frame", bus.anim_frame, (m_cnt / ANIM_DIV) % ANIM_FRAMES);
      chk("airborne", bus.airborne, m_air);
      chk("landed", bus.landed, m_land);
      chk("anim_wrap", bus.anim_wrap, m_wrap);
    end
  end

  // One clock of inputs; returns just after the edge that consumed them
  task automatic cyc(input logic t, input logic s, input logic u, input logic d, input logic k);
    @(negedge clk);
    bus.tick = t; bus.start = s; bus.up = u; bus.down = d; bus.kill = k;
    @(posedge clk);
    #1;
  endtask

  initial begin
    hu  = VAR_JUMP;
    rst = 1'b1;
    bus.tick = 1'b0; bus.start = 1'b0; bus.up = 1'b0; bus.down = 1'b0; bus.kill = 1'b0;
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("rst_state", bus.state, S_STOP);
    chk("rst_y", bus.y, 400);
    chk("rst_x", bus.x, 50);
    chk("rst_anim", bus.anim_frame, 0);
    chk("rst_air", bus.airborne, 0);
    chk("rst_landed", bus.landed, 0);
    rst = 1'b0;

    // start, then 16 running ticks
    cyc(0, 1, 0, 0, 0);
    chk("start_run", bus.state, S_RUN);
    for (int k = 1; k <= 16; k++) begin
      cyc(1, 0, 0, 0, 0);
      if (k == 7)  chk("anim_t7", bus.anim_frame, 0);
      if (k == 8)  begin chk("anim_t8", bus.anim_frame, 1); chk("wrap_t8", bus.anim_wrap, 1); end
      if (k == 16) chk("anim_t16", bus.anim_frame, 0);
      cyc(0, 0, 0, 0, 0);
    end
    chk("run16_state", bus.state, S_RUN);
    chk("run16_y", bus.y, 400);

    // full jump arc
    cyc(0, 0, 1, 0, 0);
    chk("jump_enter", bus.state, S_JUMP);
    chk("jump_air", bus.airborne, 1);
    for (int k = 1; k <= 25; k++) begin
      cyc(1, 0, hu && k < 25, 0, 0);
      if (k == 1)  chk("arc_t1", bus.y, 388);
      if (k == 12) chk("arc_t12", bus.y, 322);
      if (k == 13) chk("arc_t13", bus.y, 322);
      if (k == 24) begin chk("arc_t24_y", bus.y, 388); chk("arc_t24_air", bus.airborne, 1); end
      if (k == 25) begin
        chk("land_y", bus.y, 400);
        chk("land_pulse", bus.landed, 1);
        chk("land_state", bus.state, S_RUN);
        chk("land_air", bus.airborne, 0);
      end
      cyc(0, 0, hu && k < 25, 0, 0);
      if (k == 25) chk("land_pulse_end", bus.landed, 0);
    end

    // fast fall from tick 13, landing into DUCK
    cyc(0, 0, 1, 0, 0);
    for (int k = 1; k <= 20; k++) begin
      cyc(1, 0, hu && k < 20, k >= 13, 0);
      if (k == 19) chk("ff_t19", bus.y, 385);
      if (k == 20) begin
        chk("ff_land_y", bus.y, 400);
        chk("ff_landed", bus.landed, 1);
        chk("ff_duck", bus.state, S_DUCK);
      end
      cyc(0, 0, hu && k < 20, k >= 13, 0);
    end
    cyc(0, 0, 0, 0, 0);
    chk("duck_release", bus.state, S_RUN);

    // kill in RUN with a non-zero frame, frozen in DIE, restart
    for (int k = 1; k <= 8; k++) begin
      cyc(1, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
    end
    chk("pre_kill_anim", bus.anim_frame, 1);
    cyc(0, 0, 0, 0, 1);
    chk("kill_run", bus.state, S_DIE);
    cyc(1, 0, 0, 0, 0);
    chk("die_anim_frozen", bus.anim_frame, 1);
    cyc(0, 1, 0, 0, 0);
    chk("restart_state", bus.state, S_RUN);
    chk("restart_anim", bus.anim_frame, 0);

    // kill mid-jump freezes y; start wins over a held kill in DIE
    cyc(0, 0, 1, 0, 0);
    for (int k = 1; k <= 3; k++) begin
      cyc(1, 0, hu, 0, 0);
      cyc(0, 0, hu, 0, 0);
    end
    chk("jump3_y", bus.y, 367);
    cyc(0, 0, hu, 0, 1);
    chk("kill_jump", bus.state, S_DIE);
    chk("kill_jump_y", bus.y, 367);
    cyc(1, 0, 0, 0, 1);
    chk("die_y_frozen", bus.y, 367);
    cyc(0, 1, 0, 0, 1);
    chk("restart2_state", bus.state, S_RUN);
    chk("restart2_y", bus.y, 400);

    // kill in DUCK
    cyc(0, 0, 0, 1, 0);
    chk("duck_enter", bus.state, S_DUCK);
    cyc(0, 0, 0, 1, 1);
    chk("kill_duck", bus.state, S_DIE);
    cyc(0, 1, 0, 0, 0);

    // up and down together is no input
    cyc(0, 0, 1, 1, 0);
    chk("updown_run", bus.state, S_RUN);
    cyc(1, 0, 1, 1, 0);
    chk("updown_run_tick", bus.state, S_RUN);

    // STOP ignores kill/up/down
    rst = 1'b1;
    cyc(0, 0, 0, 0, 0);
    rst = 1'b0;
    cyc(0, 0, 0, 0, 1);
    chk("stop_kill", bus.state, S_STOP);
    cyc(0, 0, 1, 0, 0);
    chk("stop_up", bus.state, S_STOP);

    // reset at jump tick 5
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      cyc(1, 0, hu, 0, 0);
      cyc(0, 0, hu, 0, 0);
    end
    rst = 1'b1;
    cyc(1, 0, hu, 0, 0);
    chk("midrst_state", bus.state, S_STOP);
    chk("midrst_y", bus.y, 400);
    chk("midrst_landed", bus.landed, 0);
    chk("midrst_air", bus.airborne, 0);
    rst = 1'b0;
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(1, 0, hu, 0, 0);
    chk("postrst_t1", bus.y, 388);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 0);
    chk("postrst_run", bus.state, S_RUN);

`ifdef DINO_VAR_JUMP_EN
    // short hop: up released after tick 2 clamps vy 10 -> 6
    cyc(0, 0, 1, 0, 0);
    for (int k = 1; k <= 18; k++) begin
      cyc(1, 0, k <= 2, 0, 0);
      if (k == 2)  chk("hop_t2", bus.y, 377);
      if (k == 3)  chk("hop_t3", bus.y, 371);
      if (k == 8)  chk("hop_apex", bus.y, 356);
      if (k == 18) begin chk("hop_land_y", bus.y, 400); chk("hop_landed", bus.landed, 1); end
      cyc(0, 0, k <= 2, 0, 0);
    end
`endif

    cyc(0, 0, 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
